// File: rtl/ex_operand_stage_pkg.sv
// Shared definitions for the EX operand stage: function codes, shift-kind
// encoding, the ID/EX register layout and immediate extension.
package ex_operand_stage_pkg;

   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101011;

   // A bubble presents OR 0,0 to the ALU: harmless and result-free.
   localparam logic [5:0] BUBBLE_FUNCT = FN_OR;

   typedef enum logic [1:0] {
      SK_NONE  = 2'b00,
      SK_SHAMT = 2'b01,
      SK_VAR   = 2'b10
   } shift_kind_e;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [15:0] imm;
      logic        use_imm;
      logic        imm_sign;
      logic [4:0]  shamt;
      logic [1:0]  shift_kind;
      logic [5:0]  funct;
      logic [4:0]  dest;
      logic        reg_write;
      logic        mem_read;
   } idex_t;

   function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sgn);
      return sgn ? {{16{imm[15]}}, imm} : {16'h0000, imm};
   endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Bypass select for one source register: EX/MEM beats MEM/WB beats the
// register-file value; register 0 is never bypassed.
module fwd_mux (
   input  logic [4:0]  src,
   input  logic [31:0] raw,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_dest,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_dest,
   input  logic [31:0] memwb_result,
   output logic [31:0] fwd
);

   logic hit_exmem, hit_memwb;

   assign hit_exmem = exmem_reg_write && (exmem_dest != 5'd0) && (exmem_dest == src);
   assign hit_memwb = memwb_reg_write && (memwb_dest != 5'd0) && (memwb_dest == src);

   always_comb begin
      fwd = raw;
      if (hit_exmem)      fwd = exmem_result;
      else if (hit_memwb) fwd = memwb_result;
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use stall detection, operand bypass and
// ALU operand selection.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [31:0] id_rs_val,
   input  logic [31:0] id_rt_val,
   input  logic        id_use_rt,
   input  logic [15:0] id_imm,
   input  logic        id_use_imm,
   input  logic        id_imm_sign,
   input  logic [4:0]  id_shamt,
   input  logic [1:0]  id_shift_kind,
   input  logic [5:0]  id_funct,
   input  logic [4:0]  id_dest,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_dest,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_dest,
   input  logic [31:0] memwb_result,
   input  logic        flush,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [5:0]  alu_funct,
   output logic        ex_valid,
   output logic [4:0]  ex_dest,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic [31:0] ex_store_data,
   output logic        stall_id
);

   idex_t       idex_q, idex_d;
   logic [31:0] fwd_rs, fwd_rt;

   assign idex_d = '{valid:      id_valid,
                     rs:         id_rs,
                     rt:         id_rt,
                     rs_val:     id_rs_val,
                     rt_val:     id_rt_val,
                     imm:        id_imm,
                     use_imm:    id_use_imm,
                     imm_sign:   id_imm_sign,
                     shamt:      id_shamt,
                     shift_kind: id_shift_kind,
                     funct:      id_funct,
                     dest:       id_dest,
                     reg_write:  id_reg_write,
                     mem_read:   id_mem_read};

   // Load result not available until after MEM, so a dependent ID instruction waits.
   assign stall_id = id_valid && idex_q.valid && idex_q.mem_read && (idex_q.dest != 5'd0) &&
                     ((idex_q.dest == id_rs) || (id_use_rt && (idex_q.dest == id_rt)));

   always_ff @(posedge clk) begin
      if (rst)                   idex_q <= '0;
      else if (flush || stall_id) idex_q <= '0;
      else                       idex_q <= idex_d;
   end

   fwd_mux u_fwd_rs (
      .src(idex_q.rs), .raw(idex_q.rs_val),
      .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
      .fwd(fwd_rs)
   );

   fwd_mux u_fwd_rt (
      .src(idex_q.rt), .raw(idex_q.rt_val),
      .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
      .fwd(fwd_rt)
   );

   always_comb begin
      alu_in1   = '0;
      alu_in2   = '0;
      alu_funct = BUBBLE_FUNCT;
      if (idex_q.valid) begin
         alu_funct = idex_q.funct;
         case (idex_q.shift_kind)
            SK_SHAMT: begin
               alu_in1 = fwd_rt;
               alu_in2 = {27'd0, idex_q.shamt};
            end
            SK_VAR: begin
               alu_in1 = fwd_rt;
               alu_in2 = fwd_rs;
            end
            default: begin
               alu_in1 = fwd_rs;
               alu_in2 = idex_q.use_imm ? ext_imm(idex_q.imm, idex_q.imm_sign) : fwd_rt;
            end
         endcase
      end
   end

   assign ex_valid      = idex_q.valid;
   assign ex_dest       = idex_q.dest;
   assign ex_reg_write  = idex_q.valid && idex_q.reg_write;
   assign ex_mem_read   = idex_q.valid && idex_q.mem_read;
   assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: a cycle model checked every cycle plus
// literal expectations for the key scenarios.
module tb_ex_operand_stage;
   import ex_operand_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_use_rt, id_use_imm, id_imm_sign, id_reg_write, id_mem_read;
   logic [4:0]  id_rs, id_rt, id_shamt, id_dest;
   logic [31:0] id_rs_val, id_rt_val;
   logic [15:0] id_imm;
   logic [1:0]  id_shift_kind;
   logic [5:0]  id_funct;
   logic        exmem_reg_write, memwb_reg_write, flush;
   logic [4:0]  exmem_dest, memwb_dest;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] alu_in1, alu_in2, ex_store_data;
   logic [5:0]  alu_funct;
   logic        ex_valid, ex_reg_write, ex_mem_read, stall_id;
   logic [4:0]  ex_dest;

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_use_rt(id_use_rt),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_imm_sign(id_imm_sign),
      .id_shamt(id_shamt), .id_shift_kind(id_shift_kind), .id_funct(id_funct),
      .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
      .flush(flush),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_funct(alu_funct),
      .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data), .stall_id(stall_id)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_init = 1'b0;
   logic        m_valid, m_rw, m_mr, m_use_imm, m_sign;
   logic [4:0]  m_rs, m_rt, m_shamt, m_dest;
   logic [31:0] m_rsv, m_rtv;
   logic [15:0] m_imm;
   logic [1:0]  m_kind;
   logic [5:0]  m_funct;

   function automatic logic model_stall();
      return id_valid && m_valid && m_mr && (m_dest != 0) &&
             ((m_dest == id_rs) || (id_use_rt && (m_dest == id_rt)));
   endfunction

   function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] raw);
      if (r != 0 && exmem_reg_write && exmem_dest == r) return exmem_result;
      if (r != 0 && memwb_reg_write && memwb_dest == r) return memwb_result;
      return raw;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_init = 1'b1; m_valid = 0; m_rw = 0; m_mr = 0;
      end else if (flush || model_stall()) begin
         m_valid = 0; m_rw = 0; m_mr = 0;
      end else begin
         m_valid = id_valid; m_rs = id_rs; m_rt = id_rt; m_rsv = id_rs_val; m_rtv = id_rt_val;
         m_imm = id_imm; m_use_imm = id_use_imm; m_sign = id_imm_sign; m_shamt = id_shamt;
         m_kind = id_shift_kind; m_funct = id_funct; m_dest = id_dest;
         m_rw = id_reg_write; m_mr = id_mem_read;
      end
   end

   logic [31:0] e_in1, e_in2, e_imm;
   logic [5:0]  e_funct;

   always @(negedge clk) begin
      if (m_init) begin
         e_in1 = 0; e_in2 = 0; e_funct = 6'b100101;
         if (m_valid) begin
            e_funct = m_funct;
            e_imm = m_sign ? 32'($signed(m_imm)) : 32'(m_imm);
            if (m_kind == 2'd1) begin
               e_in1 = model_fwd(m_rt, m_rtv); e_in2 = 32'(m_shamt);
            end else if (m_kind == 2'd2) begin
               e_in1 = model_fwd(m_rt, m_rtv); e_in2 = model_fwd(m_rs, m_rsv);
            end else begin
               e_in1 = model_fwd(m_rs, m_rsv);
               e_in2 = m_use_imm ? e_imm : model_fwd(m_rt, m_rtv);
            end
         end
         chk("m.ex_valid", 32'(ex_valid), 32'(m_valid));
         chk("m.stall_id", 32'(stall_id), 32'(model_stall()));
         chk("m.alu_in1", alu_in1, e_in1);
         chk("m.alu_in2", alu_in2, e_in2);
         chk("m.alu_funct", 32'(alu_funct), 32'(e_funct));
         chk("m.ex_reg_write", 32'(ex_reg_write), 32'(m_valid && m_rw));
         chk("m.ex_mem_read", 32'(ex_mem_read), 32'(m_valid && m_mr));
         if (m_valid) begin
            chk("m.ex_dest", 32'(ex_dest), 32'(m_dest));
            chk("m.ex_store_data", ex_store_data, model_fwd(m_rt, m_rtv));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clr_id();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_val = 0; id_rt_val = 0; id_use_rt = 0;
      id_imm = 0; id_use_imm = 0; id_imm_sign = 0; id_shamt = 0; id_shift_kind = 0;
      id_funct = 0; id_dest = 0; id_reg_write = 0; id_mem_read = 0;
   endtask

   task automatic clr_fwd();
      exmem_reg_write = 0; exmem_dest = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_dest = 0; memwb_result = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_op(input logic [4:0] rs, input logic [31:0] rsv, input logic [4:0] dest);
      clr_id();
      id_valid = 1; id_rs = rs; id_rs_val = rsv; id_funct = FN_ADD; id_dest = dest; id_reg_write = 1;
   endtask

   task automatic load_op(input logic [4:0] dest);
      clr_id();
      id_valid = 1; id_rs = 5'd1; id_rs_val = 32'h100; id_use_imm = 1; id_imm = 16'd4;
      id_imm_sign = 1; id_funct = FN_ADD; id_dest = dest; id_reg_write = 1; id_mem_read = 1;
   endtask

   initial begin
      rst = 1; flush = 0;
      clr_id(); clr_fwd();
      step(); step();
      rst = 0;
      @(negedge clk);
      chk("reset.ex_valid", 32'(ex_valid), 32'd0);
      chk("reset.stall_id", 32'(stall_id), 32'd0);
      chk("reset.alu_funct", 32'(alu_funct), 32'h25);

      // EX/MEM bypass
      alu_op(5'd8, 32'h1, 5'd10);
      exmem_reg_write = 1; exmem_dest = 5'd8; exmem_result = 32'h10;
      step(); clr_id();
      @(negedge clk);
      chk("exmem_fwd.alu_in1", alu_in1, 32'h0000_0010);

      // both stages hit: EX/MEM wins; then MEM/WB alone
      alu_op(5'd9, 32'h1234, 5'd10);
      exmem_dest = 5'd9; exmem_result = 32'hAAAA_0000;
      memwb_reg_write = 1; memwb_dest = 5'd9; memwb_result = 32'h5555_0000;
      step(); clr_id();
      @(negedge clk);
      chk("dual_fwd.alu_in1", alu_in1, 32'hAAAA_0000);
      #1 exmem_reg_write = 0;
      #1 chk("memwb_fwd.alu_in1", alu_in1, 32'h5555_0000);
      exmem_reg_write = 1;

      // dest 0 never bypasses
      alu_op(5'd9, 32'h1234, 5'd10);
      exmem_dest = 0; memwb_dest = 0;
      step(); alu_op(5'd0, 32'h77, 5'd10);
      @(negedge clk);
      chk("dest0.alu_in1", alu_in1, 32'h1234);
      step(); clr_id();
      @(negedge clk);
      chk("r0.alu_in1", alu_in1, 32'h77);
      clr_fwd();

      // load-use: one bubble, then single issue
      load_op(5'd5);
      step();
      alu_op(5'd5, 32'h11, 5'd6); id_rt = 5'd2; id_rt_val = 32'h22; id_use_rt = 1;
      @(negedge clk);
      chk("loaduse.stall_id", 32'(stall_id), 32'd1);
      step();
      @(negedge clk);
      chk("loaduse.bubble_valid", 32'(ex_valid), 32'd0);
      chk("loaduse.bubble_funct", 32'(alu_funct), 32'b100101);
      chk("loaduse.stall_clear", 32'(stall_id), 32'd0);
      step(); clr_id();
      @(negedge clk);
      chk("loaduse.issue_valid", 32'(ex_valid), 32'd1);
      chk("loaduse.issue_in1", alu_in1, 32'h11);
      chk("loaduse.issue_in2", alu_in2, 32'h22);
      step();
      @(negedge clk);
      chk("loaduse.once", 32'(ex_valid), 32'd0);

      // immediate extension and shifts
      alu_op(5'd3, 32'h100, 5'd4); id_imm = 16'h8000; id_use_imm = 1; id_imm_sign = 1;
      step();
      id_imm_sign = 0;
      @(negedge clk);
      chk("imm_sext.alu_in2", alu_in2, 32'hFFFF_8000);
      step();
      clr_id(); id_valid = 1; id_rt = 5'd4; id_rt_val = 32'h1; id_use_rt = 1;
      id_shamt = 5'd3; id_shift_kind = 2'b01; id_funct = FN_SLL; id_dest = 5'd2; id_reg_write = 1;
      @(negedge clk);
      chk("imm_zext.alu_in2", alu_in2, 32'h0000_8000);
      step();
      clr_id(); id_valid = 1; id_rs = 5'd6; id_rs_val = 32'h2; id_rt = 5'd7; id_rt_val = 32'h80;
      id_use_rt = 1; id_shift_kind = 2'b10; id_funct = FN_SLLV; id_dest = 5'd2; id_reg_write = 1;
      @(negedge clk);
      chk("sll.alu_in1", alu_in1, 32'h1);
      chk("sll.alu_in2", alu_in2, 32'd3);
      step(); clr_id();
      @(negedge clk);
      chk("sllv.alu_in1", alu_in1, 32'h80);
      chk("sllv.alu_in2", alu_in2, 32'h2);

      // flush together with a load-use hazard
      load_op(5'd5);
      step();
      alu_op(5'd5, 32'h3, 5'd7); flush = 1;
      @(negedge clk);
      chk("flush_stall.stall_id", 32'(stall_id), 32'd1);
      step(); flush = 0; clr_id();
      @(negedge clk);
      chk("flush_stall.ex_valid", 32'(ex_valid), 32'd0);
      chk("flush_stall.ex_reg_write", 32'(ex_reg_write), 32'd0);

      // reset mid-stream
      alu_op(5'd1, 32'h5, 5'd3);
      step();
      alu_op(5'd1, 32'h9, 5'd3); rst = 1;
      @(negedge clk);
      chk("midrst.pre_valid", 32'(ex_valid), 32'd1);
      step(); rst = 0;
      @(negedge clk);
      chk("midrst.ex_valid", 32'(ex_valid), 32'd0);
      chk("midrst.alu_in1", alu_in1, 32'd0);
      chk("midrst.alu_in2", alu_in2, 32'd0);
      chk("midrst.ex_reg_write", 32'(ex_reg_write), 32'd0);
      chk("midrst.stall_id", 32'(stall_id), 32'd0);
      step(); clr_id();
      @(negedge clk);
      chk("postrst.ex_valid", 32'(ex_valid), 32'd1);
      chk("postrst.alu_in1", alu_in1, 32'h9);
      step(); step();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
